// File: rtl/display_bus_capture_pkg.sv
// rtl/display_bus_capture_pkg.sv - select codes, digit/state types and select decode for the display bus capture
package display_bus_pkg;

  localparam logic [3:0] SEL_D0    = 4'b1110;
  localparam logic [3:0] SEL_D1    = 4'b1101;
  localparam logic [3:0] SEL_D2    = 4'b1011;
  localparam logic [3:0] SEL_D3    = 4'b0111;
  localparam logic [3:0] SEL_BLANK = 4'b1111;

  typedef logic [1:0] digit_idx_t;

  typedef enum logic [1:0] {
    KIND_DIGIT,
    KIND_BLANK,
    KIND_ILLEGAL
  } sel_kind_t;

  typedef struct packed {
    sel_kind_t  kind;
    digit_idx_t idx;
  } sel_dec_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_DONE
  } state_t;

  function automatic sel_dec_t decode_sel(input logic [3:0] sel);
    sel_dec_t d;
    d.kind = KIND_ILLEGAL;
    d.idx  = 2'd0;
    unique case (sel)
      SEL_D0:    begin d.kind = KIND_DIGIT; d.idx = 2'd0; end
      SEL_D1:    begin d.kind = KIND_DIGIT; d.idx = 2'd1; end
      SEL_D2:    begin d.kind = KIND_DIGIT; d.idx = 2'd2; end
      SEL_D3:    begin d.kind = KIND_DIGIT; d.idx = 2'd3; end
      SEL_BLANK: d.kind = KIND_BLANK;
      default:   d.kind = KIND_ILLEGAL;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/display_bus_capture_if.sv
// rtl/display_bus_capture_if.sv - display bus inputs and captured-word outputs with driver/receiver modports
interface display_bus_capture_if;

  logic        ena;
  logic [3:0]  disp_out;
  logic [3:0]  disp_sel;
  logic [15:0] word;
  logic        word_valid;
  logic        frame_err;
  logic        blank;

  modport master (
    output ena, disp_out, disp_sel,
    input  word, word_valid, frame_err, blank
  );

  modport slave (
    input  ena, disp_out, disp_sel,
    output word, word_valid, frame_err, blank
  );

endinterface

// File: rtl/display_bus_capture_dwell_filter.sv
// rtl/display_bus_capture_dwell_filter.sv - input register plus saturating dwell counter, one accept per stable dwell
module display_dwell_filter #(
  parameter int                 WIDTH         = 8,
  parameter int                 STABLE_CYCLES = 2,
  parameter logic [WIDTH-1:0]   RESET_VAL     = '0
) (
  input  logic             clk0,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             accept
);

  localparam logic [3:0] STABLE = 4'(STABLE_CYCLES);

  logic [WIDTH-1:0] prev_q;
  logic [3:0]       cnt_q;
  logic [3:0]       cnt_now;
  logic             changed;

  always_ff @(posedge clk0) begin
    if (!rst_n) begin
      dout   <= RESET_VAL;
      prev_q <= RESET_VAL;
      cnt_q  <= 4'd0;
    end else begin
      dout   <= din;
      prev_q <= dout;
      cnt_q  <= en ? cnt_now : 4'd0;
    end
  end

  always_comb begin
    changed = (dout != prev_q);
    if (changed)
      cnt_now = 4'd1;
    else if (cnt_q == 4'hF)
      cnt_now = cnt_q;
    else
      cnt_now = cnt_q + 4'd1;
  end

  // Saturation at 15 would otherwise re-fire forever when STABLE_CYCLES is 15.
  assign accept = en && (cnt_now == STABLE) && (changed || (cnt_q != STABLE));

endmodule

// File: rtl/display_bus_capture.sv
// rtl/display_bus_capture.sv - reassembles filtered display-bus digits into 16-bit words, flags bad/stalled scans
module display_bus_capture #(
  parameter int STABLE_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk0,
  input  logic                  rst_n,
  display_bus_capture_if.slave  bus
);
  import display_bus_pkg::*;

  localparam logic [9:0] TMO_LAST = 10'(TIMEOUT_CYCLES - 1);

  logic [7:0]  smp;
  logic        accept;
  sel_dec_t    dec;
  logic [3:0]  nib;

  state_t      state_q, state_n;
  digit_idx_t  exp_q, exp_n;
  logic [15:0] shadow_q, shadow_n;
  logic [15:0] word_q;
  logic        wv_q, wv_n;
  logic        fe_q, fe_n;
  logic        blank_q, blank_n;
  logic [9:0]  tmo_q, tmo_n;
  logic        timeout;

  display_dwell_filter #(
    .WIDTH         (8),
    .STABLE_CYCLES (STABLE_CYCLES),
    .RESET_VAL     ({SEL_BLANK, 4'h0})
  ) u_dwell (
    .clk0   (clk0),
    .rst_n  (rst_n),
    .en     (bus.ena),
    .din    ({bus.disp_sel, bus.disp_out}),
    .dout   (smp),
    .accept (accept)
  );

  assign dec = decode_sel(smp[7:4]);
  assign nib = smp[3:0];

  always_ff @(posedge clk0) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      exp_q    <= 2'd0;
      shadow_q <= 16'h0;
      word_q   <= 16'h0;
      wv_q     <= 1'b0;
      fe_q     <= 1'b0;
      blank_q  <= 1'b0;
      tmo_q    <= 10'd0;
    end else begin
      state_q  <= state_n;
      exp_q    <= exp_n;
      shadow_q <= shadow_n;
      if (wv_n)
        word_q <= shadow_q;
      wv_q     <= wv_n;
      fe_q     <= fe_n;
      blank_q  <= blank_n;
      tmo_q    <= tmo_n;
    end
  end

  always_comb begin
    state_n  = state_q;
    exp_n    = exp_q;
    shadow_n = shadow_q;
    blank_n  = blank_q;
    wv_n     = 1'b0;
    fe_n     = 1'b0;
    tmo_n    = (accept || (state_q != ST_COLLECT)) ? 10'd0 : tmo_q + 10'd1;
    timeout  = (state_q == ST_COLLECT) && (tmo_q == TMO_LAST);

    if (!bus.ena) begin
      state_n = ST_IDLE;
      tmo_n   = 10'd0;
    end else begin
      if (accept)
        blank_n = (dec.kind == KIND_BLANK);

      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            if (dec.kind == KIND_ILLEGAL) begin
              fe_n = 1'b1;
            end else if ((dec.kind == KIND_DIGIT) && (dec.idx == 2'd0)) begin
              shadow_n[3:0] = nib;
              exp_n         = 2'd1;
              state_n       = ST_COLLECT;
            end
          end
        end

        ST_COLLECT: begin
          // An accept in the same cycle as the timeout keeps the frame alive.
          if (accept) begin
            unique case (dec.kind)
              KIND_DIGIT: begin
                if (dec.idx == exp_q) begin
                  shadow_n[{dec.idx, 2'b00} +: 4] = nib;
                  if (exp_q == 2'd3)
                    state_n = ST_DONE;
                  else
                    exp_n = exp_q + 2'd1;
                end else if (dec.idx == (exp_q - 2'd1)) begin
                  shadow_n[{dec.idx, 2'b00} +: 4] = nib;
                end else begin
                  fe_n = 1'b1;
                  if (dec.idx == 2'd0) begin
                    shadow_n[3:0] = nib;
                    exp_n         = 2'd1;
                  end else begin
                    state_n = ST_IDLE;
                  end
                end
              end
              KIND_BLANK: state_n = ST_IDLE;
              default: begin
                fe_n    = 1'b1;
                state_n = ST_IDLE;
              end
            endcase
          end else if (timeout) begin
            fe_n    = 1'b1;
            state_n = ST_IDLE;
          end
        end

        ST_DONE: begin
          // word_valid owns this cycle; only a fresh d0 is carried forward.
          wv_n    = 1'b1;
          state_n = ST_IDLE;
          if (accept && (dec.kind == KIND_DIGIT) && (dec.idx == 2'd0)) begin
            shadow_n[3:0] = nib;
            exp_n         = 2'd1;
            state_n       = ST_COLLECT;
          end
        end

        default: state_n = ST_IDLE;
      endcase
    end
  end

  assign bus.word       = word_q;
  assign bus.word_valid = wv_q & bus.ena;
  assign bus.frame_err  = fe_q & bus.ena;
  assign bus.blank      = blank_q;

endmodule

// File: tb/tb_display_bus_capture.sv
// tb/tb_display_bus_capture.sv - directed self-checking bench for display_bus_capture
module tb_display_bus_capture;
  import display_bus_pkg::*;

  logic clk0 = 1'b0;
  logic rst_n = 1'b0;

  display_bus_capture_if bus();

  display_bus_capture #(.STABLE_CYCLES(2), .TIMEOUT_CYCLES(64)) dut (
    .clk0  (clk0),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk0 = ~clk0;

  int checks = 0;
  int fails = 0;
  int cyc = 0;
  int wv_cnt, fe_cnt, both_cnt, wv_first, wv_last, fe_cyc, blank_fall;
  logic [15:0] wv_words[$];
  logic blank_prev = 1'b0;

  // One clock edge, then observe outputs 1 time unit later.
  task automatic tick();
    @(posedge clk0);
    #1;
    cyc++;
    if (bus.word_valid) begin
      if (wv_cnt == 0) wv_first = cyc;
      wv_last = cyc;
      wv_cnt++;
      wv_words.push_back(bus.word);
    end
    if (bus.frame_err) begin
      fe_cnt++;
      fe_cyc = cyc;
    end
    if (bus.word_valid && bus.frame_err) both_cnt++;
    if (blank_prev && !bus.blank) blank_fall = cyc;
    blank_prev = bus.blank;
  endtask

  task automatic clear_mon();
    wv_cnt = 0; fe_cnt = 0; wv_first = -1; wv_last = -1; fe_cyc = -1; blank_fall = -1;
    wv_words.delete();
  endtask

  function automatic logic [3:0] sel_of(input int i);
    case (i)
      0: return SEL_D0;
      1: return SEL_D1;
      2: return SEL_D2;
      default: return SEL_D3;
    endcase
  endfunction

  task automatic drive_digit(input logic [3:0] sel, input logic [3:0] nib, input int n);
    bus.disp_sel = sel;
    bus.disp_out = nib;
    repeat (n) tick();
  endtask

  task automatic drive_frame(input logic [15:0] w);
    for (int i = 0; i < 4; i++) drive_digit(sel_of(i), w[i*4 +: 4], 2);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.ena = 1'b1;
    drive_digit(SEL_BLANK, 4'h0, 2);
    checks++; if (bus.word !== 16'h0) begin fails++; $display("FAIL reset_word: got %h want 0000", bus.word); end
    checks++; if (bus.word_valid !== 1'b0) begin fails++; $display("FAIL reset_word_valid: got %b want 0", bus.word_valid); end
    checks++; if (bus.frame_err !== 1'b0) begin fails++; $display("FAIL reset_frame_err: got %b want 0", bus.frame_err); end
    checks++; if (bus.blank !== 1'b0) begin fails++; $display("FAIL reset_blank: got %b want 0", bus.blank); end
    rst_n = 1'b1;
  endtask

  task automatic test_nominal();
    int t_first;
    clear_mon();
    drive_frame(16'hA5C3);
    t_first = cyc;
    drive_frame(16'hA5C3);
    drive_frame(16'hA5C3);
    repeat (3) tick();
    checks++; if (wv_cnt !== 3) begin fails++; $display("FAIL nominal_pulses: got %0d want 3", wv_cnt); end
    checks++; if (wv_first !== t_first + 2) begin fails++; $display("FAIL nominal_latency: got cycle %0d want %0d", wv_first, t_first + 2); end
    checks++; if (wv_last - wv_first !== 16) begin fails++; $display("FAIL nominal_period: got %0d want 16", wv_last - wv_first); end
    for (int i = 0; i < wv_words.size(); i++) begin
      checks++; if (wv_words[i] !== 16'hA5C3) begin fails++; $display("FAIL nominal_word_%0d: got %h want a5c3", i, wv_words[i]); end
    end
    checks++; if (bus.word !== 16'hA5C3) begin fails++; $display("FAIL nominal_word_held: got %h want a5c3", bus.word); end
    checks++; if (fe_cnt !== 0) begin fails++; $display("FAIL nominal_frame_err: got %0d want 0", fe_cnt); end
  endtask

  task automatic test_mid_change();
    clear_mon();
    drive_digit(SEL_D0, 4'h3, 2);
    drive_digit(SEL_D1, 4'hC, 2);
    drive_digit(SEL_D2, 4'h5, 1);
    drive_digit(SEL_D2, 4'h2, 2);
    drive_digit(SEL_D3, 4'h1, 2);
    drive_frame(16'h1234);
    repeat (3) tick();
    checks++; if (wv_cnt !== 2) begin fails++; $display("FAIL mid_pulses: got %0d want 2", wv_cnt); end
    checks++; if (wv_words[0] !== 16'h12C3) begin fails++; $display("FAIL mid_mixed_word: got %h want 12c3", wv_words[0]); end
    checks++; if (wv_words[1] !== 16'h1234) begin fails++; $display("FAIL mid_new_word: got %h want 1234", wv_words[1]); end
    checks++; if (fe_cnt !== 0) begin fails++; $display("FAIL mid_frame_err: got %0d want 0", fe_cnt); end
  endtask

  task automatic test_out_of_order();
    int t;
    clear_mon();
    drive_digit(SEL_D0, 4'h3, 2);
    drive_digit(SEL_D1, 4'hC, 2);
    drive_digit(SEL_D3, 4'hA, 2);
    t = cyc;
    repeat (3) tick();
    checks++; if (fe_cnt !== 1) begin fails++; $display("FAIL ooo_err_count: got %0d want 1", fe_cnt); end
    checks++; if (fe_cyc !== t + 1) begin fails++; $display("FAIL ooo_err_cycle: got %0d want %0d", fe_cyc, t + 1); end
    checks++; if (wv_cnt !== 0) begin fails++; $display("FAIL ooo_word_valid: got %0d want 0", wv_cnt); end
    checks++; if (bus.word !== 16'h1234) begin fails++; $display("FAIL ooo_word_held: got %h want 1234", bus.word); end
  endtask

  task automatic test_illegal_blank();
    int t;
    clear_mon();
    drive_digit(SEL_D0, 4'h1, 2);
    drive_digit(SEL_D1, 4'h2, 2);
    drive_digit(4'b1100, 4'h0, 2);
    t = cyc;
    drive_digit(SEL_D2, 4'h3, 2);
    drive_digit(SEL_D3, 4'h4, 2);
    checks++; if (fe_cnt !== 1) begin fails++; $display("FAIL illegal_err_count: got %0d want 1", fe_cnt); end
    checks++; if (fe_cyc !== t + 1) begin fails++; $display("FAIL illegal_err_cycle: got %0d want %0d", fe_cyc, t + 1); end
    checks++; if (wv_cnt !== 0) begin fails++; $display("FAIL illegal_idle: got %0d word_valid want 0", wv_cnt); end
    drive_digit(SEL_BLANK, 4'h0, 4);
    checks++; if (bus.blank !== 1'b1) begin fails++; $display("FAIL blank_set: got %b want 1", bus.blank); end
    checks++; if (fe_cnt !== 1) begin fails++; $display("FAIL blank_no_err: got %0d want 1", fe_cnt); end
    drive_digit(SEL_D0, 4'hF, 2);
    t = cyc;
    drive_digit(SEL_D1, 4'hE, 2);
    drive_digit(SEL_D2, 4'hE, 2);
    drive_digit(SEL_D3, 4'hB, 2);
    repeat (3) tick();
    checks++; if (blank_fall !== t + 1) begin fails++; $display("FAIL blank_clear_cycle: got %0d want %0d", blank_fall, t + 1); end
    checks++; if (wv_cnt !== 1) begin fails++; $display("FAIL blank_resume_pulses: got %0d want 1", wv_cnt); end
    checks++; if (bus.word !== 16'hBEEF) begin fails++; $display("FAIL blank_resume_word: got %h want beef", bus.word); end
    checks++; if (fe_cnt !== 1) begin fails++; $display("FAIL blank_resume_err: got %0d want 1", fe_cnt); end
  endtask

  task automatic test_timeout();
    int c0;
    clear_mon();
    drive_digit(SEL_D0, 4'h7, 2);
    c0 = cyc;
    drive_digit(SEL_D1, 4'h9, 70);
    checks++; if (fe_cnt !== 1) begin fails++; $display("FAIL timeout_count: got %0d want 1", fe_cnt); end
    checks++; if (fe_cyc !== c0 + 67) begin fails++; $display("FAIL timeout_cycle: got %0d want %0d", fe_cyc, c0 + 67); end
    checks++; if (wv_cnt !== 0) begin fails++; $display("FAIL timeout_word_valid: got %0d want 0", wv_cnt); end
  endtask

  task automatic test_reset_mid();
    clear_mon();
    drive_digit(SEL_D0, 4'h1, 2);
    drive_digit(SEL_D1, 4'h2, 2);
    drive_digit(SEL_D2, 4'h3, 1);
    rst_n = 1'b0;
    drive_digit(SEL_D2, 4'h3, 1);
    checks++; if (bus.word !== 16'h0) begin fails++; $display("FAIL midreset_word: got %h want 0000", bus.word); end
    checks++; if (bus.word_valid !== 1'b0) begin fails++; $display("FAIL midreset_word_valid: got %b want 0", bus.word_valid); end
    checks++; if (bus.frame_err !== 1'b0) begin fails++; $display("FAIL midreset_frame_err: got %b want 0", bus.frame_err); end
    checks++; if (bus.blank !== 1'b0) begin fails++; $display("FAIL midreset_blank: got %b want 0", bus.blank); end
    rst_n = 1'b1;
  endtask

  task automatic test_enable();
    int t;
    drive_frame(16'h1234);
    repeat (3) tick();
    checks++; if (bus.word !== 16'h1234) begin fails++; $display("FAIL ena_pre_word: got %h want 1234", bus.word); end
    clear_mon();
    bus.ena = 1'b0;
    drive_frame(16'h5678);
    drive_frame(16'h5678);
    drive_digit(SEL_D0, 4'h8, 2);
    drive_digit(SEL_D1, 4'h7, 2);
    checks++; if (wv_cnt !== 0) begin fails++; $display("FAIL ena_off_word_valid: got %0d want 0", wv_cnt); end
    checks++; if (fe_cnt !== 0) begin fails++; $display("FAIL ena_off_frame_err: got %0d want 0", fe_cnt); end
    checks++; if (bus.word !== 16'h1234) begin fails++; $display("FAIL ena_off_word_held: got %h want 1234", bus.word); end
    bus.ena = 1'b1;
    drive_digit(SEL_D2, 4'h6, 2);
    drive_digit(SEL_D3, 4'h5, 2);
    drive_frame(16'h5678);
    t = cyc;
    repeat (3) tick();
    checks++; if (wv_cnt !== 1) begin fails++; $display("FAIL ena_on_pulses: got %0d want 1", wv_cnt); end
    checks++; if (wv_first !== t + 2) begin fails++; $display("FAIL ena_on_latency: got cycle %0d want %0d", wv_first, t + 2); end
    checks++; if (bus.word !== 16'h5678) begin fails++; $display("FAIL ena_on_word: got %h want 5678", bus.word); end
  endtask

  initial begin
    both_cnt = 0;
    bus.ena = 1'b1;
    bus.disp_sel = SEL_BLANK;
    bus.disp_out = 4'h0;
    clear_mon();
    test_reset();
    test_nominal();
    test_mid_change();
    test_out_of_order();
    test_illegal_blank();
    test_timeout();
    test_reset_mid();
    test_enable();
    checks++; if (both_cnt !== 0) begin fails++; $display("FAIL exclusive_pulses: got %0d overlapping cycles want 0", both_cnt); end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
